// File: rtl/accel_job_sequencer.sv
// accel_job_sequencer: second bus master that offloads a batch of factorial jobs to the accelerator.
// Define SEQ_TIMEOUT_EN to add a per-word watchdog on the accelerator done flag.
module accel_job_sequencer #(
  parameter logic [31:0] ACCEL_BASE = 32'h0000_0800,
  parameter int unsigned DONE_BIT   = 3,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_done,
  output logic [31:0] addr_dm,
  output logic [31:0] wd_dm,
  output logic        we,
  input  logic [31:0] rd_dm,
  input  logic [3:0]  ex_int
);
  // IDLE wait start | NEXT word/end decision | RD_SRC fetch operand | WR_ARG/WR_GO program accel
  // WAIT_DONE wait done flag | RD_RES fetch result (clears flag) | WR_DST store result
  typedef enum logic [2:0] {
    S_IDLE, S_NEXT, S_RD_SRC, S_WR_ARG, S_WR_GO, S_WAIT_DONE, S_RD_RES, S_WR_DST
  } state_e;

  localparam logic [1:0] DONE_IDX = DONE_BIT[1:0];

  state_e      state_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [31:0] data_q;
  logic [15:0] cnt_q;
  logic [15:0] words_done_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] offset;
  logic        acc_done;
  logic        unused_ex_int;

  assign offset        = {14'd0, words_done_q, 2'b00};
  assign acc_done      = ex_int[DONE_IDX];
  assign unused_ex_int = ^ex_int;

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tmr_q;
  logic          error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = words_done_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      words_done_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tmr_q        <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_q        <= src_addr;
            dst_q        <= dst_addr;
            cnt_q        <= count;
            words_done_q <= '0;
            busy_q       <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            error_q      <= 1'b0;
`endif
            state_q      <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (words_done_q == cnt_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_RD_SRC;
          end
        end
        S_RD_SRC: begin
          data_q  <= rd_dm;
          state_q <= S_WR_ARG;
        end
        S_WR_ARG: state_q <= S_WR_GO;
        S_WR_GO: begin
`ifdef SEQ_TIMEOUT_EN
          tmr_q   <= TW'(TIMEOUT - 1);
`endif
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // A flag that was already latched when we arrive is taken immediately.
          if (acc_done) begin
            state_q <= S_RD_RES;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (tmr_q == '0) begin
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
`endif
        end
        S_RD_RES: begin
          data_q  <= rd_dm;
          state_q <= S_WR_DST;
        end
        S_WR_DST: begin
          words_done_q <= words_done_q + 16'd1;
          state_q      <= S_NEXT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_dm = '0;
    wd_dm   = '0;
    we      = 1'b0;
    case (state_q)
      S_RD_SRC: addr_dm = src_q + offset;
      S_WR_ARG: begin
        addr_dm = ACCEL_BASE;
        wd_dm   = data_q;
        we      = 1'b1;
      end
      S_WR_GO: begin
        addr_dm = ACCEL_BASE + 32'h4;
        wd_dm   = 32'h1;
        we      = 1'b1;
      end
      S_RD_RES: addr_dm = ACCEL_BASE + 32'hC;
      S_WR_DST: begin
        addr_dm = dst_q + offset;
        wd_dm   = data_q;
        we      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_accel_job_sequencer.sv
// Bench for accel_job_sequencer: directed vector table, reset and timeout sequences, and
// randomized jobs checked against a data-memory + factorial-accelerator model.
module tb_accel_job_sequencer;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] count = '0;
  logic        busy, done, error, we;
  logic [15:0] words_done;
  logic [31:0] addr_dm, wd_dm, rd_dm;
  logic [3:0]  ex_int;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  accel_job_sequencer #(.TIMEOUT(16)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .busy(busy), .done(done), .error(error), .words_done(words_done),
    .addr_dm(addr_dm), .wd_dm(wd_dm), .we(we), .rd_dm(rd_dm), .ex_int(ex_int)
  );

  // ---------------- SoC model: 2 KB data memory + accelerator at 0x800 ----------------
  logic [31:0] dmem [512];
  logic [31:0] acc_op;
  logic        acc_flag;
  bit          acc_hang = 1'b0;
  int          acc_cnt;
  int          go_lat;
  int          lat_q[$];

  function automatic logic [31:0] fact(input logic [31:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= 20; i++) if (i <= n) r = r * i;
    return r;
  endfunction

  assign ex_int = {acc_flag, 3'b101};

  always_comb begin
    rd_dm = '0;
    if (addr_dm[31:4] == 28'h000_0080) begin
      case (addr_dm[3:0])
        4'h0:    rd_dm = acc_op;
        4'h8:    rd_dm = {31'b0, acc_flag};
        4'hC:    rd_dm = fact(acc_op);
        default: rd_dm = '0;
      endcase
    end else if (addr_dm < 32'h800) begin
      rd_dm = dmem[addr_dm[10:2]];
    end
  end

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      acc_flag <= 1'b0;
      acc_cnt  <= 0;
      acc_op   <= '0;
    end else begin
      if (we && addr_dm < 32'h800) dmem[addr_dm[10:2]] <= wd_dm;
      if (we && addr_dm == 32'h800) acc_op <= wd_dm;
      if (we && addr_dm == 32'h804) begin
        go_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
        if (acc_hang) acc_cnt <= 0;
        else if (go_lat == 0) acc_flag <= 1'b1;
        else acc_cnt <= go_lat;
      end else if (acc_cnt > 0) begin
        acc_cnt <= acc_cnt - 1;
        if (acc_cnt == 1) acc_flag <= 1'b1;
      end
      if (!we && addr_dm[31:4] == 28'h000_0080) acc_flag <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  bit rdres_prev = 1'b0;
  always @(negedge Clk) begin
    if (rdres_prev && Rst) chk("flag_clear_after_rd_res", {31'b0, ex_int[3]}, 32'd0);
    rdres_prev = Rst && busy && !we && (addr_dm == 32'h80C);
  end

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input bit hold, output int cyc, output int ndone, output bit bus_seen);
    bit fin;
    cyc = 0; ndone = 0; bus_seen = 1'b0; fin = 1'b0;
    @(negedge Clk);
    src_addr = s; dst_addr = d; count = n; start = 1'b1;
    @(negedge Clk);
    if (!hold) start = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (busy) cyc++;
      if (done) begin ndone++; fin = 1'b1; end
      if (we || addr_dm != 32'h0) bus_seen = 1'b1;
      if (hold) begin
        start = busy;
        src_addr = $urandom; dst_addr = $urandom; count = 16'($urandom);
      end
      if (!fin) @(negedge Clk);
    end
    start = 1'b0;
    chk("job_done_within_budget", {31'b0, fin}, 32'd1);
    @(negedge Clk);
    if (done) ndone++;
  endtask

  task automatic verify_job(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input bit hold, input int lat, input bit rand_lat,
                            output int cyc, output int exp_cyc, output bit bus_seen);
    logic [31:0] exp_res[$];
    logic [31:0] guard;
    int nd, l;
    exp_cyc = 1;
    for (int i = 0; i < int'(n); i++) begin
      exp_res.push_back(fact(dmem[(s >> 2) + i]));
      l = rand_lat ? int'($urandom_range(0, 4)) : lat;
      lat_q.push_back(l);
      exp_cyc += 7 + l;
    end
    guard = dmem[(d >> 2) + n];
    run_job(s, d, n, hold, cyc, nd, bus_seen);
    chk({tag, "_done_pulses"}, nd, 32'd1);
    chk({tag, "_words_done"}, {16'd0, words_done}, {16'd0, n});
    chk({tag, "_error"}, {31'b0, error}, 32'd0);
    for (int i = 0; i < int'(n); i++)
      chk($sformatf("%s_res%0d", tag, i), dmem[(d >> 2) + i], exp_res[i]);
    chk({tag, "_guard"}, dmem[(d >> 2) + n], guard);
  endtask

  typedef struct {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [15:0]      cnt;
    int               lat;
    bit               hold;
    int               cyc;
    logic [2:0][31:0] res;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[5];
    int   cyc, ecyc, nd, k;
    bit   bs, ok;

    for (int i = 0; i < 512; i++) dmem[i] = $urandom;
    dmem[64] = 32'd3; dmem[65] = 32'd5; dmem[66] = 32'd0; dmem[67] = 32'd4;

    vt[0] = '{32'h100, 32'h200, 16'd3, 0, 1'b0, 22, {32'd1,  32'd120, 32'd6}};
    vt[1] = '{32'h100, 32'h300, 16'd0, 0, 1'b0, 1,  {32'd0,  32'd0,   32'd0}};
    vt[2] = '{32'h104, 32'h210, 16'd1, 3, 1'b0, 11, {32'd0,  32'd0,   32'd120}};
    vt[3] = '{32'h108, 32'h220, 16'd2, 1, 1'b1, 17, {32'd0,  32'd24,  32'd1}};
    vt[4] = '{32'h100, 32'h230, 16'd3, 2, 1'b1, 28, {32'd1,  32'd120, 32'd6}};

    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_we", {31'b0, we}, 32'd0);
    chk("reset_addr", addr_dm, 32'd0);
    chk("reset_words_done", {16'd0, words_done}, 32'd0);
    chk("reset_error", {31'b0, error}, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    foreach (vt[i]) begin
      verify_job($sformatf("vec%0d", i), vt[i].src, vt[i].dst, vt[i].cnt, vt[i].hold,
                 vt[i].lat, 1'b0, cyc, ecyc, bs);
      chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
      if (vt[i].cnt == 16'd0) chk($sformatf("vec%0d_no_bus", i), {31'b0, bs}, 32'd0);
      for (int j = 0; j < 3; j++)
        if (j < int'(vt[i].cnt))
          chk($sformatf("vec%0d_lit%0d", i, j), dmem[(vt[i].dst >> 2) + j], vt[i].res[j]);
    end

    // Reset while the second word's operand write is on the bus.
    lat_q.push_back(0);
    @(negedge Clk);
    src_addr = 32'h100; dst_addr = 32'h500; count = 16'd3; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    k = 0;
    while (!(we && words_done == 16'd1) && k < 100) begin @(negedge Clk); k++; end
    chk("rst_mid_write_reached", {31'b0, we}, 32'd1);
    #2 Rst = 1'b0;
    #1;
    chk("rst_async_we", {31'b0, we}, 32'd0);
    chk("rst_async_addr", addr_dm, 32'd0);
    chk("rst_async_wd", wd_dm, 32'd0);
    chk("rst_async_busy", {31'b0, busy}, 32'd0);
    chk("rst_async_done", {31'b0, done}, 32'd0);
    chk("rst_async_words_done", {16'd0, words_done}, 32'd0);
    lat_q.delete();
    @(negedge Clk);
    Rst = 1'b1;
    ok = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge Clk);
      if (busy || done || we || addr_dm != 32'h0) ok = 1'b0;
    end
    chk("rst_idle_after_release", {31'b0, ok}, 32'd1);
    verify_job("post_rst", 32'h100, 32'h240, 16'd2, 1'b0, 0, 1'b0, cyc, ecyc, bs);
    chk("post_rst_cycles", cyc, ecyc);

    for (int j = 0; j < 12; j++) begin
      logic [31:0] s, d;
      logic [15:0] n;
      s = 32'($urandom_range(0, 100)) << 2;
      d = 32'h400 + (32'($urandom_range(0, 100)) << 2);
      n = 16'($urandom_range(0, 6));
      for (int i = 0; i < int'(n); i++) dmem[(s >> 2) + i] = 32'($urandom_range(0, 12));
      verify_job($sformatf("rnd%0d", j), s, d, n, 1'($urandom_range(0, 1)), 0, 1'b1,
                 cyc, ecyc, bs);
      chk($sformatf("rnd%0d_cycles", j), cyc, ecyc);
    end

`ifdef SEQ_TIMEOUT_EN
    acc_hang = 1'b1;
    run_job(32'h100, 32'h600, 16'd2, 1'b0, cyc, nd, bs);
    chk("timeout_cycles", cyc, 32'd20);
    chk("timeout_done_pulses", nd, 32'd1);
    chk("timeout_error", {31'b0, error}, 32'd1);
    chk("timeout_words_done", {16'd0, words_done}, 32'd0);
    acc_hang = 1'b0;
    run_job(32'h100, 32'h600, 16'd0, 1'b0, cyc, nd, bs);
    chk("timeout_error_cleared", {31'b0, error}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
